ea_calc: RTL

- Effective-address sequencer that sits directly downstream of the instruction register.
- Consumes a fetched 36-bit instruction word: I = bit 13, X = bits 14:17, Y = bits 18:35.
- Resolves indexing through the AC file and follows indirect chains through the memory read port.
- Delivers the final 18-bit effective address to the microsequencer / operand-fetch stage with a start/done handshake.

---
 rtl/ea_calc_pkg.sv | 36 +++
 rtl/ea_calc.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ea_calc_pkg.sv
// Shared constants for the effective-address sequencer: state codes,
// instruction-word field positions, abort codes and the index adder.
package ea_calc_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] EVAL  = 3'd1;
  localparam logic [2:0] MEMRD = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ABORT = 3'd4;

  // Bit 0 is the MSB of the 36-bit word.
  localparam int I_BIT = 13;
  localparam int X_LO  = 14;
  localparam int X_HI  = 17;
  localparam int Y_LO  = 18;
  localparam int Y_HI  = 35;

  localparam logic [1:0] ABORT_NONE  = 2'b00;
  localparam logic [1:0] ABORT_PF    = 2'b01;
  localparam logic [1:0] ABORT_INT   = 2'b10;
  localparam logic [1:0] ABORT_LIMIT = 2'b11;

  // AC0 is never used as an index register; the carry out of bit 18 is dropped.
  function automatic logic [17:0] indexSum(input logic [17:0] y,
                                           input logic [3:0]  x,
                                           input logic [17:0] acRight);
    logic [17:0] result;
    if (x != 4'd0) begin
      result = y + acRight;
    end else begin
      result = y;
    end
    return result;
  endfunction

endpackage

// File: rtl/ea_calc.sv
// Effective-address sequencer: indexes through the AC file and follows
// indirect words through the memory read port until a final address is found.
module ea_calc
  import ea_calc_pkg::*;
#(
  parameter int MAXIND = 1023,
  parameter int CNTW   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        start,
  input  logic [0:35] instr,
  input  logic        prevEN,
  output logic [3:0]  acADDR,
  input  logic [0:35] acDATA,
  output logic        memREQ,
  output logic [17:0] memADDR,
  output logic        memPREV,
  input  logic        memACK,
  input  logic [0:35] memDATA,
  input  logic        memERR,
  input  logic        intPEND,
  output logic        busy,
  output logic        done,
  output logic [17:0] ea,
  output logic        eaPREV,
  output logic        abort,
  output logic [1:0]  abortCODE
);

  localparam logic [CNTW-1:0] LEVEL_MAX  = CNTW'(MAXIND);
  localparam logic [CNTW-1:0] LEVEL_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] LEVEL_ONE  = CNTW'(1);

  logic [2:0]      state_r;
  logic [2:0]      nextState_s;
  logic            iBit_r;
  logic [17:0]     yOff_r;
  logic [CNTW-1:0] level_r;
  logic [17:0]     sum_s;
  logic            atLimit_s;
  logic            intTaken_s;
  logic            unusedBits_s;

  // Opcode/AC fields of the instruction and the left half of the AC word carry no meaning here.
  assign unusedBits_s = ^{instr[0:12], memDATA[0:12], acDATA[0:17]};

  // Index adder and the two abort conditions evaluated in EVAL.
  always_comb begin
    sum_s      = indexSum(yOff_r, acADDR, acDATA[Y_LO:Y_HI]);
    atLimit_s  = (level_r == LEVEL_MAX);
    intTaken_s = intPEND && (level_r != LEVEL_ZERO);
  end

  // Next-state decode.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          nextState_s = EVAL;
        end else begin
          nextState_s = IDLE;
        end
      end
      EVAL: begin
        if (!iBit_r) begin
          nextState_s = DONE;
        end else if (atLimit_s || intTaken_s) begin
          nextState_s = ABORT;
        end else begin
          nextState_s = MEMRD;
        end
      end
      MEMRD: begin
        if (memACK) begin
          if (memERR) begin
            nextState_s = ABORT;
          end else begin
            nextState_s = EVAL;
          end
        end else begin
          nextState_s = MEMRD;
        end
      end
      DONE:    nextState_s = IDLE;
      ABORT:   nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register and the status/handshake outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
      memREQ  <= 1'b0;
    end else if (clken) begin
      state_r <= nextState_s;
      busy    <= (nextState_s != IDLE);
      done    <= (nextState_s == DONE);
      abort   <= (nextState_s == ABORT);
      memREQ  <= (nextState_s == MEMRD);
    end
  end

  // Field latches, level counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iBit_r    <= 1'b0;
      acADDR    <= 4'd0;
      yOff_r    <= 18'd0;
      level_r   <= LEVEL_ZERO;
      ea        <= 18'd0;
      memADDR   <= 18'd0;
      memPREV   <= 1'b0;
      eaPREV    <= 1'b0;
      abortCODE <= ABORT_NONE;
    end else if (clken) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            iBit_r    <= instr[I_BIT];
            acADDR    <= instr[X_LO:X_HI];
            yOff_r    <= instr[Y_LO:Y_HI];
            eaPREV    <= prevEN;
            memPREV   <= prevEN;
            level_r   <= LEVEL_ZERO;
            abortCODE <= ABORT_NONE;
          end
        end
        EVAL: begin
          if (!iBit_r) begin
            ea <= sum_s;
          end else if (atLimit_s) begin
            abortCODE <= ABORT_LIMIT;
          end else if (intTaken_s) begin
            abortCODE <= ABORT_INT;
          end else begin
            memADDR <= sum_s;
            ea      <= sum_s;
          end
        end
        MEMRD: begin
          if (memACK) begin
            if (memERR) begin
              abortCODE <= ABORT_PF;
            end else begin
              iBit_r  <= memDATA[I_BIT];
              acADDR  <= memDATA[X_LO:X_HI];
              yOff_r  <= memDATA[Y_LO:Y_HI];
              level_r <= level_r + LEVEL_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
